// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer sitting directly upstream of the CSR file.
// Picks one trap per visit to IDLE (commit exception, else a machine
// interrupt with priority ext > sw > timer), drains the pipeline, strobes the
// CSR context switch, then redirects fetch to the MTVEC the CSR file returns.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_exc_valid/code/pc       commit-stage exception
//   i_commit_valid/npc        retiring instruction and its next PC
//   i_irq_ext/timer           level interrupts; i_irq_sw edge interrupt
//   i_mstatus_mie, i_mie_en   global / per-source enables ([0]sw [1]tmr [2]ext)
//   i_pipe_empty              nothing in flight
//   i_mtvec                   trap vector from the CSR file
//   o_flush, o_cs, o_redirect, o_busy   Moore decodes of the state
//   o_cause, o_npc            context-switch payload
//   o_redirect_pc             fetch redirect target
//   o_mip                     pending bits, same order as i_mie_en
//   o_drain_to                sticky drain-timeout flag
module trap_ctrl #(
  parameter int XLEN      = 64,
  parameter int DRAIN_MAX = 15
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_exc_valid,
  input  logic [4:0]      i_exc_code,
  input  logic [XLEN-1:0] i_exc_pc,
  input  logic            i_commit_valid,
  input  logic [XLEN-1:0] i_commit_npc,
  input  logic            i_irq_ext,
  input  logic            i_irq_timer,
  input  logic            i_irq_sw,
  input  logic            i_mstatus_mie,
  input  logic [2:0]      i_mie_en,
  input  logic            i_pipe_empty,
  input  logic [XLEN-1:0] i_mtvec,
  output logic            o_flush,
  output logic            o_cs,
  output logic [XLEN-1:0] o_cause,
  output logic [XLEN-1:0] o_npc,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic [2:0]      o_mip,
  output logic            o_busy,
  output logic            o_drain_to
);

  localparam int CW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_TRAP, S_VEC, S_REDIR} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_mip;
  logic            r_sw_prev;
  logic [XLEN-1:0] r_cause, r_npc, r_rpc;
  logic            r_dto;

  logic [2:0]      w_pend;
  logic            w_take_irq;
  logic [4:0]      w_irq_code;
  logic            w_drain_tmo;
  logic            w_sw_trap;

  assign w_pend      = r_mip & i_mie_en;
  assign w_take_irq  = i_mstatus_mie & (|w_pend) & i_commit_valid;
  // Last DRAIN cycle before the counter would reach DRAIN_MAX.
  assign w_drain_tmo = (r_cnt == CW'(DRAIN_MAX - 1));
  // The trap being switched is a software interrupt (cause = irq | 3).
  assign w_sw_trap   = r_cause[XLEN-1] & (r_cause[XLEN-2:0] == (XLEN-1)'(3));

  always_comb begin
    w_irq_code = 5'd7;
    if (w_pend[2])      w_irq_code = 5'd11;
    else if (w_pend[0]) w_irq_code = 5'd3;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_flush    = 1'b0;
    o_cs       = 1'b0;
    o_redirect = 1'b0;
    o_busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_exc_valid || w_take_irq) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        o_flush = 1'b1;
        if (i_pipe_empty || w_drain_tmo) w_next = S_TRAP;
      end
      S_TRAP: begin
        o_flush = 1'b1;
        o_cs    = 1'b1;
        w_next  = S_VEC;
      end
      S_VEC: begin
        o_flush = 1'b1;
        w_next  = S_REDIR;
      end
      S_REDIR: begin
        o_flush    = 1'b1;
        o_redirect = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mip     <= '0;
      r_sw_prev <= 1'b0;
      r_cause   <= '0;
      r_npc     <= '0;
      r_rpc     <= '0;
      r_cnt     <= '0;
      r_dto     <= 1'b0;
    end else begin
      r_mip[2]  <= i_irq_ext;
      r_mip[1]  <= i_irq_timer;
      r_sw_prev <= i_irq_sw;
      // A new SW edge beats the clear from a concurrent SW trap.
      if (i_irq_sw && !r_sw_prev)              r_mip[0] <= 1'b1;
      else if (r_state == S_TRAP && w_sw_trap) r_mip[0] <= 1'b0;

      // Exception has priority; a coincident interrupt stays pending in MIP.
      if (r_state == S_IDLE) begin
        if (i_exc_valid) begin
          r_cause <= XLEN'(i_exc_code);
          r_npc   <= i_exc_pc;
        end else if (w_take_irq) begin
          r_cause <= {1'b1, {(XLEN-6){1'b0}}, w_irq_code};
          r_npc   <= i_commit_npc;
        end
      end

      if (r_state == S_DRAIN) begin
        if (w_next != S_DRAIN) r_cnt <= '0;
        else                   r_cnt <= r_cnt + 1'b1;
        // An empty pipe on the last cycle is a normal drain, not a timeout.
        if (!i_pipe_empty && w_drain_tmo) r_dto <= 1'b1;
      end

      // CSR file loaded MTVEC on the CS edge, so it is valid during VEC.
      if (r_state == S_VEC) r_rpc <= i_mtvec;
    end
  end

  assign o_cause       = r_cause;
  assign o_npc         = r_npc;
  assign o_redirect_pc = r_rpc;
  assign o_mip         = r_mip;
  assign o_drain_to    = r_dto;

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized bench for trap_ctrl. The reference works per transaction: the
// trap decision is taken from the modelled pending set, and the whole trap
// is laid out as a timeline (drain length L, CS at L+1, REDIRECT at L+3).
module tb_trap_ctrl;
  localparam int XLEN = 64;
  localparam int DMAX = 15;
  localparam logic [63:0] IRQ = 64'h8000_0000_0000_0000;

  logic clk = 1'b0, rst = 1'b1;
  logic exc_valid = 0, commit_valid = 0, irq_ext = 0, irq_timer = 0, irq_sw = 0;
  logic mstatus_mie = 0, pipe_empty = 0;
  logic [4:0] exc_code = '0;
  logic [2:0] mie_en = '0;
  logic [63:0] exc_pc = '0, commit_npc = '0, mtvec = '0;
  logic flush, cs, redirect, busy, drain_to;
  logic [63:0] cause, npc, redirect_pc;
  logic [2:0] mip;

  int n_chk = 0, n_fail = 0;
  bit noise_irq = 0;
  // Model of what the trap controller has latched.
  logic m_ext = 0, m_tmr = 0, m_sw = 0, m_swprev = 0, m_dto = 0;

  trap_ctrl #(.XLEN(XLEN), .DRAIN_MAX(DMAX)) dut (
    .i_clk(clk), .i_reset(rst), .i_exc_valid(exc_valid), .i_exc_code(exc_code),
    .i_exc_pc(exc_pc), .i_commit_valid(commit_valid), .i_commit_npc(commit_npc),
    .i_irq_ext(irq_ext), .i_irq_timer(irq_timer), .i_irq_sw(irq_sw),
    .i_mstatus_mie(mstatus_mie), .i_mie_en(mie_en), .i_pipe_empty(pipe_empty),
    .i_mtvec(mtvec), .o_flush(flush), .o_cs(cs), .o_cause(cause), .o_npc(npc),
    .o_redirect(redirect), .o_redirect_pc(redirect_pc), .o_mip(mip),
    .o_busy(busy), .o_drain_to(drain_to));

  always #5 clk = ~clk;

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one edge, updating the pending model from the inputs at that edge.
  task automatic step(input bit clr_sw);
    @(posedge clk);
    if (rst) begin
      m_ext = 0; m_tmr = 0; m_sw = 0; m_swprev = 0; m_dto = 0;
    end else begin
      if (irq_sw && !m_swprev) m_sw = 1;
      else if (clr_sw)         m_sw = 0;
      m_swprev = irq_sw; m_ext = irq_ext; m_tmr = irq_timer;
    end
    #1;
  endtask

  task automatic rand_irq();
    irq_ext = ($urandom % 4 == 0); irq_timer = ($urandom % 4 == 0);
    irq_sw = ($urandom % 3 == 0);
  endtask

  // One IDLE cycle with the given trigger; if a trap is taken, follow it to
  // the end with the pipe staying busy for w DRAIN cycles.
  task automatic txn(input logic ev, input logic [4:0] code, input logic [63:0] pc,
                     input logic cv, input logic [63:0] cnpc, input int w,
                     input logic [63:0] tv);
    logic [2:0] pend; logic take, swt, tmo; logic [63:0] ecause, enpc; int L;
    exc_valid = ev; exc_code = code; exc_pc = pc; commit_valid = cv; commit_npc = cnpc;
    pipe_empty = 1'($urandom); mtvec = r64();
    pend = {m_ext, m_tmr, m_sw} & mie_en;
    take = mstatus_mie & (|pend) & cv;
    swt = 0; ecause = '0; enpc = '0;
    if (ev) begin
      ecause = {59'd0, code}; enpc = pc;
    end else if (take) begin
      enpc = cnpc;
      if (pend[2])      ecause = IRQ | 64'd11;
      else if (pend[0]) begin ecause = IRQ | 64'd3; swt = 1; end
      else              ecause = IRQ | 64'd7;
    end
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_flush", 64'(flush), 64'd0);
    chk("idle_cs", 64'(cs), 64'd0);
    chk("idle_redir", 64'(redirect), 64'd0);
    chk("idle_mip", 64'(mip), 64'({m_ext, m_tmr, m_sw}));
    chk("idle_dto", 64'(drain_to), 64'(m_dto));
    step(0);
    if (!(ev || take)) return;
    tmo = (w >= DMAX);
    L = tmo ? DMAX : w + 1;
    for (int i = 1; i <= L + 3; i++) begin
      exc_valid = 1'($urandom); commit_valid = 1'($urandom);
      exc_pc = r64(); commit_npc = r64();
      if (noise_irq) rand_irq();
      pipe_empty = (i > w);
      mtvec = (i == L + 2) ? tv : r64();
      @(negedge clk);
      chk("flush", 64'(flush), 64'd1);
      chk("busy", 64'(busy), 64'd1);
      chk("cs", 64'(cs), 64'(i == L + 1));
      chk("redirect", 64'(redirect), 64'(i == L + 3));
      chk("mip", 64'(mip), 64'({m_ext, m_tmr, m_sw}));
      chk("drain_to", 64'(drain_to), 64'(m_dto));
      if (i == L + 1) begin
        chk("cause", cause, ecause);
        chk("npc", npc, enpc);
      end
      if (i == L + 3) chk("redirect_pc", redirect_pc, tv);
      step(i == L + 1 && swt);
      if (i == L && tmo) m_dto = 1;
    end
    exc_valid = 0; commit_valid = 0;
  endtask

  initial begin
    int w;
    step(0); step(0);
    rst = 0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cause", cause, 64'd0);
    chk("rst_npc", npc, 64'd0);
    chk("rst_rpc", redirect_pc, 64'd0);
    chk("rst_mip", 64'(mip), 64'd0);
    chk("rst_dto", 64'(drain_to), 64'd0);
    step(0);

    // Exception, empty pipe: CS next cycle, REDIRECT two after.
    txn(1, 5'd2, 64'h1000, 0, 0, 0, 64'h8000_0008);

    // Ext + timer pending: ext first, then timer once ext drops.
    mstatus_mie = 1; mie_en = 3'b111; irq_ext = 1; irq_timer = 1;
    txn(0, 0, 0, 0, 0, 0, 0);
    txn(0, 0, 0, 1, 64'h2004, 2, 64'h100);
    irq_ext = 0;
    txn(0, 0, 0, 0, 0, 0, 0);
    txn(0, 0, 0, 1, 64'h3000, 0, 64'h200);

    // Exception beats a pending timer; timer follows.
    txn(1, 5'd11, 64'h4000, 1, 64'h4004, 1, 64'h300);
    txn(0, 0, 0, 1, 64'h5000, 0, 64'h400);
    irq_timer = 0;
    txn(0, 0, 0, 0, 0, 0, 0);

    // Drain timeout.
    txn(1, 5'd5, 64'h6000, 0, 0, 20, 64'h500);

    // SW edge with interrupts globally off, then enable.
    mstatus_mie = 0; irq_sw = 1;
    txn(0, 0, 0, 1, 64'h7000, 0, 0);
    irq_sw = 0;
    txn(0, 0, 0, 1, 64'h7000, 0, 0);
    mstatus_mie = 1;
    txn(0, 0, 0, 1, 64'h7004, 3, 64'h600);
    txn(0, 0, 0, 0, 0, 0, 0);

    // Reset while in VEC.
    mstatus_mie = 0; exc_valid = 1; exc_code = 5'd4; exc_pc = 64'h9000;
    step(0);
    exc_valid = 0; pipe_empty = 1;
    step(0); step(0);
    @(negedge clk);
    chk("vec_flush", 64'(flush), 64'd1);
    chk("vec_cs", 64'(cs), 64'd0);
    rst = 1;
    step(0);
    rst = 0;
    @(negedge clk);
    chk("rstv_busy", 64'(busy), 64'd0);
    chk("rstv_flush", 64'(flush), 64'd0);
    chk("rstv_redir", 64'(redirect), 64'd0);
    chk("rstv_cs", 64'(cs), 64'd0);
    chk("rstv_cause", cause, 64'd0);
    chk("rstv_npc", npc, 64'd0);
    chk("rstv_rpc", redirect_pc, 64'd0);
    chk("rstv_dto", 64'(drain_to), 64'd0);
    step(0);
    txn(1, 5'd7, 64'hA000, 0, 0, 0, 64'h700);

    // Randomized traffic.
    noise_irq = 1;
    for (int k = 0; k < 60; k++) begin
      rand_irq();
      mstatus_mie = 1'($urandom); mie_en = 3'($urandom);
      w = $urandom_range(0, 17);
      if (w == DMAX - 1) w = DMAX;
      txn($urandom % 3 == 0, 5'($urandom), r64(), 1'($urandom), r64(), w, r64());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer directly upstream of the CSR file.
- Watches commit-stage exceptions and the three machine interrupt lines, and picks one trap with fixed priority.
- Drains the pipeline, then drives the CSR file's context-switch strobe (CS, CAUSE, NPC).
- Finally redirects fetch to the vector address the CSR file returns on MTVEC.

Parameters:
- XLEN, 64, datapath width of CAUSE/NPC/PC buses.
- DRAIN_MAX, 15, max cycles spent in DRAIN before forcing the trap; the drain counter is clog2(DRAIN_MAX+1) bits.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- EXC_VALID  in  1  commit-stage instruction raised an exception this cycle.
- EXC_CODE  in  5  exception code for EXC_VALID.
- EXC_PC  in  XLEN  PC of the faulting instruction.
- COMMIT_VALID  in  1  an instruction retires this cycle.
- COMMIT_NPC  in  XLEN  next PC of the retiring instruction.
- IRQ_EXT  in  1  external interrupt, level.
- IRQ_TIMER  in  1  timer interrupt, level.
- IRQ_SW  in  1  software interrupt, edge.
- MSTATUS_MIE  in  1  global machine interrupt enable.
- MIE_EN  in  3  per-source enables: [0] SW, [1] timer, [2] ext.
- PIPE_EMPTY  in  1  no instructions in flight.
- MTVEC  in  XLEN  trap target from the CSR file.
- FLUSH  out  1  stall fetch and kill younger instructions.
- CS  out  1  one-cycle context-switch strobe to the CSR file.
- CAUSE  out  XLEN  trap cause to the CSR file.
- NPC  out  XLEN  return PC to the CSR file.
- REDIRECT  out  1  one-cycle fetch redirect.
- REDIRECT_PC  out  XLEN  redirect target.
- MIP  out  3  pending bits, same bit order as MIE_EN.
- BUSY  out  1  state is not IDLE.
- DRAIN_TO  out  1  sticky flag: a drain timeout has occurred.

Behaviour:
- Reset, sampled on a CLK edge: state=IDLE; MIP, CAUSE, NPC, REDIRECT_PC, drain counter and DRAIN_TO all cleared to 0.
- RESET asserted in any state returns to IDLE on that edge; CS and REDIRECT are 0 in the following cycle.
- FLUSH, CS, REDIRECT and BUSY are Moore outputs decoded from the state register.
- MIP[2] and MIP[1] are registered copies of IRQ_EXT and IRQ_TIMER, giving 1 cycle of latency.
- MIP[0] sets on an IRQ_SW rising edge (previous-value register) and clears on the TRAP cycle of an SW trap. If set and clear coincide, set wins.
- take_irq = MSTATUS_MIE & |(MIP & MIE_EN) & COMMIT_VALID.
- IDLE, EXC_VALID=1: CAUSE = zero-extended EXC_CODE (bit XLEN-1 = 0); NPC = EXC_PC; go to DRAIN.
- IDLE, else take_irq=1: pick priority ext > sw > timer. CAUSE = {1, zeros, code}, with code 11/3/7 respectively. NPC = COMMIT_NPC; go to DRAIN.
- IDLE, EXC_VALID and take_irq both set: the exception wins and the interrupt stays pending.
- DRAIN: FLUSH=1 and the counter increments each cycle.
  - PIPE_EMPTY=1 -> TRAP.
  - Counter reaches DRAIN_MAX -> TRAP with DRAIN_TO set (sticky until reset).
  - Clear the counter on leaving DRAIN.
- TRAP: FLUSH=1 and CS=1 for exactly one cycle; CAUSE and NPC are held stable; next state VEC.
- VEC: FLUSH=1. The CSR file loads MTVEC on the CS edge, so MTVEC is valid this cycle. Capture REDIRECT_PC <= MTVEC on the exit edge; next state REDIR.
- REDIR: REDIRECT=1 and FLUSH=1; next state IDLE. A new trap can be accepted in the cycle after REDIR.
- EXC_VALID and COMMIT_VALID are ignored outside IDLE, because the pipeline is being flushed. Interrupts keep accumulating in MIP.
- Minimum latency: EXC_VALID sampled at edge E0 with PIPE_EMPTY=1 gives CS in cycle E1-E2 and REDIRECT in cycle E3-E4.

Test Plan:
- EXC_VALID=1, EXC_CODE=2, EXC_PC=0x1000, PIPE_EMPTY=1, MTVEC returned as 0x8000_0008 -> CS pulses 1 cycle with CAUSE=0x2, NPC=0x1000; REDIRECT 2 cycles later with REDIRECT_PC=0x8000_0008.
- MSTATUS_MIE=1, MIE_EN=3'b111, IRQ_EXT=IRQ_TIMER=1, COMMIT_VALID=1, COMMIT_NPC=0x2004 -> CAUSE=0x8000_0000_0000_000B, NPC=0x2004; timer stays in MIP and is taken on the next trap with CAUSE low bits=7.
- EXC_VALID=1 (code 11) with IRQ_TIMER pending and enabled, same cycle -> CAUSE=0xB with bit63=0; timer trap follows after REDIR.
- PIPE_EMPTY held 0 -> FLUSH high for 15 DRAIN cycles, then CS with DRAIN_TO=1.
- IRQ_SW pulsed for 1 cycle with MSTATUS_MIE=0 -> MIP[0] stays 1 and no CS. Raise MSTATUS_MIE=1 -> trap with CAUSE low bits=3, and MIP[0] clears on CS.
- RESET asserted during VEC -> next cycle state IDLE, REDIRECT=0, all outputs 0; a new exception afterwards is handled normally.
